add_serial_driver: RTL and testbench

- Transaction sequencer that sits on both sides of the 8-bit serial adder.
- Accepts operand pairs on a valid/ready input stream and issues one load pulse (en) to the adder with the operands held stable.
- Waits a fixed latency, samples the adder's out bus and returns the sum on a valid/ready result stream.
- Checks each sum against a golden a+b and counts mismatches, so wrong keys or bad decoy transitions are visible.

---
 rtl/add_serial_pkg.sv | 20 ++
 rtl/add_serial_driver_if.sv | 37 +++
 rtl/sat_counter.sv | 21 ++
 rtl/add_serial_driver.sv | 119 +++++++++++
 tb/tb_add_serial_driver.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_serial_pkg.sv
// Shared types and constants for the serial-adder transaction driver.
package add_serial_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LATENCY = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  // Wide enough to hold LATENCY-1 for any LATENCY >= 1.
  function automatic int wait_cnt_w(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/add_serial_driver_if.sv
// Operand stream, adder-side bus and result stream of the serial-adder driver.
interface add_serial_driver_if
  import add_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             add_en;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_out;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_mismatch;
  logic [CNT_W-1:0] err_count;

  // The driver itself.
  modport master (
    input  in_valid, in_a, in_b, add_out, res_ready,
    output in_ready, add_en, add_a, add_b, res_valid, res_sum, res_mismatch, err_count
  );

  // Operand producer, adder and result consumer seen from outside.
  modport slave (
    output in_valid, in_a, in_b, add_out, res_ready,
    input  in_ready, add_en, add_a, add_b, res_valid, res_sum, res_mismatch, err_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous reset and clear.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/add_serial_driver.sv
// Sequences one operand pair at a time through the serial adder and checks the sum.
module add_serial_driver
  import add_serial_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = 8
) (
  input logic                 clk,
  input logic                 rst,
  add_serial_driver_if.master bus
);

  localparam int                WCNT_W    = wait_cnt_w(LATENCY);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(LATENCY - 1);

  state_t            state, state_next;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_next;

  logic [WIDTH-1:0]  a_q, b_q, exp_q, sum_q;
  logic              en_q, valid_q, mismatch_q;
  logic [CNT_W-1:0]  err_cnt;

  logic              accept, capture, deliver, mismatch_now;

  assign bus.in_ready = (state == S_IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign mismatch_now = (bus.add_out != exp_q);

  // Sampling edge is always the end of cycle en+LATENCY: S_WAIT covers LATENCY-1
  // cycles, so it is skipped entirely when LATENCY is 1.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_next    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    deliver       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        wait_cnt_next = WAIT_LOAD;
        state_next    = (LATENCY == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_next = wait_cnt - 1'b1;
        if (wait_cnt_next == '0) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture    = 1'b1;
        state_next = S_OUT;
      end
      S_OUT: begin
        if (valid_q && bus.res_ready) begin
          deliver    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Operands only move on acceptance, so the adder sees them steady until S_IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      exp_q      <= '0;
      sum_q      <= '0;
      mismatch_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      en_q <= (state_next == S_ISSUE);
      if (accept) begin
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
        exp_q <= WIDTH'(bus.in_a + bus.in_b);
      end
      if (capture) begin
        sum_q      <= bus.add_out;
        mismatch_q <= mismatch_now;
        valid_q    <= 1'b1;
      end else if (deliver) begin
        valid_q <= 1'b0;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (capture && mismatch_now),
    .count (err_cnt)
  );

  assign bus.add_en       = en_q;
  assign bus.add_a        = a_q;
  assign bus.add_b        = b_q;
  assign bus.res_valid    = valid_q;
  assign bus.res_sum      = sum_q;
  assign bus.res_mismatch = mismatch_q;
  assign bus.err_count    = err_cnt;

endmodule

// File: tb/tb_add_serial_driver.sv
// Self-checking bench: table vectors, handshake/reset corners, random traffic, CNT_W=2 saturation.
module tb_add_serial_driver;

  localparam int LAT  = 9;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int ref_err = 0;

  add_serial_driver_if #(.WIDTH(8), .CNT_W(8)) bus ();
  add_serial_driver_if #(.WIDTH(8), .CNT_W(2)) bus1 ();

  add_serial_driver #(.WIDTH(8), .LATENCY(LAT), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  add_serial_driver #(.WIDTH(8), .LATENCY(LAT1), .CNT_W(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adders: garbage until LATENCY cycles after en, then the sum
  // (fault 1 = stuck at zero, fault 2 = LSB flipped).
  int       age0 = 1000;
  int       age1 = 1000;
  int       fault0 = 0;
  logic     fault1 = 1'b0;
  logic [7:0] sum0, sum1;

  always @(posedge clk) begin
    if (bus.add_en) age0 <= 1;
    else if (age0 < 1000) age0 <= age0 + 1;
    if (bus1.add_en) age1 <= 1;
    else if (age1 < 1000) age1 <= age1 + 1;
  end

  assign sum0 = bus.add_a + bus.add_b;
  assign sum1 = bus1.add_a + bus1.add_b;
  assign bus.add_out  = (fault0 == 1) ? 8'h00 :
                        (age0 < LAT)  ? (sum0 ^ 8'hA5) :
                        (fault0 == 2) ? (sum0 ^ 8'h01) : sum0;
  assign bus1.add_out = fault1 ? 8'h00 : ((age1 < LAT1) ? (sum1 ^ 8'hA5) : sum1);

  function automatic logic [7:0] ref_out(input logic [7:0] a, input logic [7:0] b, input int fault);
    logic [7:0] s;
    s = a + b;
    case (fault)
      1:       return 8'h00;
      2:       return s ^ 8'h01;
      default: return s;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Present a pair and wait (bounded) for in_ready; returns at the negedge of the acceptance cycle.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input string tag, output int acc);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ".accept"}, guard < 100, 1);
    acc = cyc;
  endtask

  // Follows one transaction from acceptance to the result handshake.
  task automatic collect(input int acc, input logic [7:0] a, input logic [7:0] b, input int hold,
                         input logic [7:0] exp_sum, input logic exp_mis, input int exp_err,
                         input string tag);
    int   guard, en_cnt, en_cyc;
    logic stable, held;
    guard = 0; en_cnt = 0; en_cyc = -1; stable = 1'b1; held = 1'b1;
    bus.res_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.res_valid && guard < 60) begin
      if (bus.add_en) begin
        en_cnt++;
        en_cyc = cyc;
      end
      if (bus.add_a !== a || bus.add_b !== b) stable = 1'b0;
      @(negedge clk);
      guard++;
    end
    check({tag, ".valid_seen"}, bus.res_valid, 1);
    check({tag, ".latency"}, cyc, acc + LAT + 2);
    check({tag, ".en_pulses"}, en_cnt, 1);
    check({tag, ".en_cycle"}, en_cyc, acc + 1);
    check({tag, ".sum"}, bus.res_sum, exp_sum);
    check({tag, ".mismatch"}, bus.res_mismatch, exp_mis);
    check({tag, ".err_count"}, bus.err_count, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_sum !== exp_sum || bus.res_mismatch !== exp_mis || bus.in_ready)
        held = 1'b0;
      if (bus.add_a !== a || bus.add_b !== b) stable = 1'b0;
    end
    if (hold > 0) check({tag, ".held"}, held, 1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, ".valid_drop"}, bus.res_valid, 0);
    check({tag, ".ready_back"}, bus.in_ready, 1);
    check({tag, ".stable"}, stable, 1);
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic exp_mis,
                      input int exp_err, input string tag);
    int acc, guard;
    guard = 0;
    @(negedge clk);
    bus1.in_valid  = 1'b1;
    bus1.in_a      = a;
    bus1.in_b      = b;
    bus1.res_ready = 1'b1;
    while (!bus1.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    acc = cyc;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    guard = 0;
    while (!bus1.res_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ".latency"}, cyc, acc + LAT1 + 2);
    check({tag, ".mismatch"}, bus1.res_mismatch, exp_mis);
    check({tag, ".err_count"}, bus1.err_count, exp_err);
    @(negedge clk);
    check({tag, ".valid_drop"}, bus1.res_valid, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         fault;
    int         hold;
    logic [7:0] exp_sum;
    logic       exp_mis;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   acc, guard, f, hold;
    logic [7:0] a, b, es;
    logic em, flag;
    string tag;

    vecs[0] = '{8'h03, 8'h05, 0, 0, 8'h08, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 0, 2, 8'h00, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 1, 1, 8'h00, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 0, 0, 8'h00, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 2, 0, 8'h81, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1, 3, 8'h00, 1'b0};

    bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.res_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.res_ready = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.add_en", bus.add_en, 0);
    check("rst.add_a", bus.add_a, 0);
    check("rst.res_valid", bus.res_valid, 0);
    check("rst.res_sum", bus.res_sum, 0);
    check("rst.err_count", bus.err_count, 0);
    check("rst.in_ready_low", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.in_ready_high", bus.in_ready, 1);

    // LATENCY=1, CNT_W=2: one clean result, then saturation 1,2,3,3.
    fault1 = 1'b0;
    run1(8'h03, 8'h04, 1'b0, 0, "l1.clean");
    fault1 = 1'b1;
    for (int i = 0; i < 4; i++)
      run1(8'h01, 8'h02, 1'b1, (i < 3) ? i + 1 : 3, $sformatf("sat%0d", i));
    fault1 = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fault0 = vecs[i].fault;
      if (vecs[i].exp_mis && ref_err < 255) ref_err++;
      tag = $sformatf("vec%0d", i);
      send(vecs[i].a, vecs[i].b, tag, acc);
      collect(acc, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp_sum, vecs[i].exp_mis, ref_err, tag);
    end
    fault0 = 0;

    // Result stalled for 5 cycles while a new pair waits on the input.
    send(8'h21, 8'h43, "hs1", acc);
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.res_valid && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("hs1.latency", cyc, acc + LAT + 2);
    check("hs1.sum", bus.res_sum, 8'h64);
    flag = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h10;
    bus.in_b     = 8'h20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.in_ready || !bus.res_valid || bus.res_sum !== 8'h64 || bus.add_a !== 8'h21) flag = 1'b0;
    end
    check("hs1.stall_hold", flag, 1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("hs2.valid_drop", bus.res_valid, 0);
    check("hs2.idle_ready", bus.in_ready, 1);
    check("hs2.add_a_old", bus.add_a, 8'h21);
    acc = cyc;
    collect(acc, 8'h10, 8'h20, 0, 8'h30, 1'b0, ref_err, "hs2");

    // Random traffic against the reference model.
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      f = $urandom_range(0, 5);
      fault0 = (f == 4) ? 1 : (f == 5) ? 2 : 0;
      hold = $urandom_range(0, 3);
      es = ref_out(a, b, fault0);
      em = (es != 8'(a + b));
      if (em && ref_err < 255) ref_err++;
      tag = $sformatf("rnd%0d", i);
      send(a, b, tag, acc);
      collect(acc, a, b, hold, es, em, ref_err, tag);
    end
    fault0 = 0;

    // Reset in the middle of S_WAIT drops the transaction silently.
    send(8'h55, 8'h11, "abort", acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (cyc < acc + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.add_en", bus.add_en, 0);
    check("abort.add_a", bus.add_a, 0);
    check("abort.add_b", bus.add_b, 0);
    check("abort.res_valid", bus.res_valid, 0);
    check("abort.res_sum", bus.res_sum, 0);
    check("abort.res_mismatch", bus.res_mismatch, 0);
    check("abort.err_count", bus.err_count, 0);
    check("abort.in_ready_rst", bus.in_ready, 0);
    rst = 1'b0;
    ref_err = 0;
    @(negedge clk);
    check("abort.in_ready", bus.in_ready, 1);
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_valid) flag = 1'b1;
    end
    check("abort.no_result", flag, 0);

    send(8'h0A, 8'h0B, "post", acc);
    collect(acc, 8'h0A, 8'h0B, 1, 8'h15, 1'b0, ref_err, "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
